bus_demux_1x2: RTL and testbench
================================

BUS_DEMUX_1X2 -- requirements
Module: bus_demux_1x2

Interface
REQ-001 Parameters SHALL be as follows:
- ADDR_W, default 32, address width.
- DATA_W, default 32, data width.
- IO_BASE, default 32'h0000_8000, base of the peripheral region.
- IO_MASK, default 32'hFFFF_8000, address compare mask.
- TIMEOUT, default 16, cycles allowed per transaction before an error response; legal range 2..255.

REQ-002 Ports SHALL be as follows:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  upstream request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables.
- rsp_valid  out  1  single-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 on writes and errors.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- m0_valid / m1_valid  out  1  request to memory (m0) / peripheral (m1) port.
- m0_ready / m1_ready  in  1  port accepts the request.
- m0_we, m0_addr, m0_wdata, m0_be / m1_* equivalents  out  as upstream  latched request fields.
- m0_rvalid / m1_rvalid  in  1  port completion; reads and writes both complete this way.
- m0_rdata / m1_rdata  in  DATA_W  port read data.

Function
REQ-003 The block SHALL hold one outstanding transaction at a time, controlled by FSM states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: req_ready SHALL be 1 only in IDLE; on req_valid && req_ready it SHALL latch we, addr, wdata, be and sel, then move to ISSUE.
REQ-005 Address decode: sel SHALL be 1 (peripheral, m1) when (req_addr & IO_MASK) == IO_BASE, else 0 (memory, m0); every address maps to exactly one port.
REQ-006 ISSUE: the selected mX_valid SHALL be 1 with the latched fields held stable, and the other port's valid SHALL be 0; on mX_ready=1 the FSM SHALL move to WAIT.
REQ-007 WAIT: on the selected mX_rvalid=1 the block SHALL capture mX_rdata (reads) or 0 (writes) and move to RESP; mX_valid SHALL be 0 in WAIT.
REQ-008 RESP: rsp_valid SHALL be 1 for exactly one cycle, with rsp_rdata/rsp_err valid that cycle; the FSM SHALL then return to IDLE. There is no upstream backpressure.
REQ-009 Minimum latency: request accepted at edge N -> mX_valid high in cycle N+1 -> ready at N+1 and rvalid at N+2 -> rsp_valid in cycle N+3.
REQ-010 The timeout counter SHALL clear on acceptance and increment every cycle in ISSUE or WAIT; on reaching TIMEOUT it SHALL force RESP with rsp_err=1 and rsp_rdata=0, and mX_valid SHALL drop.
REQ-011 If rvalid and the timeout terminal count coincide, rvalid SHALL win and rsp_err SHALL be 0.
REQ-012 rvalid from the non-selected port, or any rvalid in IDLE, ISSUE or RESP, SHALL be ignored.
REQ-013 req_valid while not in IDLE SHALL have no effect; the request is not latched.
REQ-014 In every cycle outside RESP, rsp_valid SHALL be 0 and rsp_rdata/rsp_err SHALL hold their last values.

Reset
REQ-015 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE, the counter to 0, and all outputs to 0 (req_ready=0 during reset, 1 in the first cycle after release).
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no response generated; downstream valids SHALL drop immediately.

Verification
REQ-017 Read to memory: addr 0x0000_0010 with m0 ready and rvalid immediate, rdata 0xDEADBEEF -> m1_valid never asserts; rsp_valid 3 cycles after acceptance with rdata 0xDEADBEEF and err 0.
REQ-018 Write to peripheral: addr 0x0000_8004, wdata 0x55, be 4'b0001; m1_ready delayed 3 cycles -> m1 fields stable throughout; rsp_valid with rdata 0 and err 0.
REQ-019 Timeout: read to 0x0000_8000, m1_ready never asserted -> after 16 cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, and m1_valid low thereafter.
REQ-020 Stray completion: m1_rvalid=1 pulsed while an m0 read is in WAIT -> pulse ignored; response carries m0_rdata only after m0_rvalid.
REQ-021 Reset mid-op: rst_n pulled low while in WAIT -> all outputs 0 before the next clk edge, no rsp_valid; a new request after release completes normally.
REQ-022 Back-to-back: req_valid held high with two requests -> second accepted only in the cycle after the first response, and req_ready=0 from acceptance through RESP.

Source files
------------

// File: rtl/bus_demux_1x2.sv
// ---------------------------------------------------------------------------
// bus_demux_1x2
//
// Purpose:
//   Routes one upstream request at a time to either the memory port (m0) or
//   the peripheral port (m1), based on an address compare. It waits for the
//   chosen port to complete, then returns a one-cycle response upstream. If
//   the port does not finish within TIMEOUT cycles, the transaction is closed
//   with an error response.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (byte enables are DATA_W/8 wide)
//   IO_BASE  base of the peripheral region
//   IO_MASK  mask applied to the address before comparing with IO_BASE
//   TIMEOUT  cycles allowed in ISSUE+WAIT before an error response (2..255)
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           upstream request handshake
//   req_we/addr/wdata/be          upstream request fields
//   rsp_valid/rsp_rdata/rsp_err   one-cycle upstream response
//   mX_valid/mX_ready             downstream request handshake (X = 0, 1)
//   mX_we/addr/wdata/be           latched request fields towards port X
//   mX_rvalid/mX_rdata            downstream completion and read data
// ---------------------------------------------------------------------------
module bus_demux_1x2 #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h0000_8000,
    parameter logic [ADDR_W-1:0] IO_MASK = 32'hFFFF_8000,
    parameter int                TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,

    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic                  m0_valid,
    input  logic                  m0_ready,
    output logic                  m0_we,
    output logic [ADDR_W-1:0]     m0_addr,
    output logic [DATA_W-1:0]     m0_wdata,
    output logic [DATA_W/8-1:0]   m0_be,
    input  logic                  m0_rvalid,
    input  logic [DATA_W-1:0]     m0_rdata,

    output logic                  m1_valid,
    input  logic                  m1_ready,
    output logic                  m1_we,
    output logic [ADDR_W-1:0]     m1_addr,
    output logic [DATA_W-1:0]     m1_wdata,
    output logic [DATA_W/8-1:0]   m1_be,
    input  logic                  m1_rvalid,
    input  logic [DATA_W-1:0]     m1_rdata
);

    localparam int BE_W = DATA_W / 8;

    // The last cycle allowed in ISSUE+WAIT has count TIMEOUT-1.
    localparam logic [7:0] CNT_TERM = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                sel_q, sel_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                addrIsIo;
    logic                selReady;
    logic                selRvalid;
    logic [DATA_W-1:0]   selRdata;
    logic                cntTerm;

    // Exactly one port per address: peripheral on a masked match, else memory.
    assign addrIsIo = ((req_addr & IO_MASK) == IO_BASE);

    // Only the selected port's handshake signals are considered. This makes
    // stray completions from the other port invisible to the FSM.
    assign selReady  = sel_q ? m1_ready  : m0_ready;
    assign selRvalid = sel_q ? m1_rvalid : m0_rvalid;
    assign selRdata  = sel_q ? m1_rdata  : m0_rdata;
    assign cntTerm   = (cnt_q == CNT_TERM);

    // State register and all latched fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            sel_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic.
    // The response registers change only on entry to RESP, so they keep
    // their last values at all other times. In WAIT, a completion takes
    // priority over the timeout. In ISSUE, the timeout takes priority, so
    // no completion can be accepted after the error response.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    sel_d   = addrIsIo;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (cntTerm) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else if (selReady) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (selRvalid) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : selRdata;
                    state_d     = RESP;
                end else if (cntTerm) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode.
    // req_ready is gated with rst_n so that it reads 0 while reset is held.
    // It rises as soon as reset is released.
    always_comb begin
        req_ready = rst_n && (state_q == IDLE);
        m0_valid  = (state_q == ISSUE) && !sel_q;
        m1_valid  = (state_q == ISSUE) &&  sel_q;
        rsp_valid = (state_q == RESP);
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Both ports see the same latched fields; only the valid strobes differ.
    assign m0_we    = we_q;
    assign m0_addr  = addr_q;
    assign m0_wdata = wdata_q;
    assign m0_be    = be_q;
    assign m1_we    = we_q;
    assign m1_addr  = addr_q;
    assign m1_wdata = wdata_q;
    assign m1_be    = be_q;

endmodule

// File: tb/tb_bus_demux_1x2.sv
// ---------------------------------------------------------------------------
// tb_bus_demux_1x2
//
// Purpose:
//   Directed, self-checking bench for bus_demux_1x2 with default parameters.
//   A table of transactions is played through a cycle-level downstream
//   responder. Hand-written sequences cover reset, back-to-back requests and
//   an abandoned transaction.
// ---------------------------------------------------------------------------
module tb_bus_demux_1x2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic        m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;

    int checks = 0;
    int errors = 0;

    bus_demux_1x2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_be     (m0_be),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_be     (m1_be),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed transaction, together with its hand-computed response.
    // readyDly:  ISSUE cycles before the selected port raises ready
    //            (255 means the port never raises ready).
    // rvalidDly: WAIT cycles before the selected port completes.
    // expEdges:  clock edges from the acceptance edge to the first cycle
    //            in which rsp_valid is high.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          readyDly;
        int          rvalidDly;
        logic [31:0] rdata;
        bit          stray;
        logic        expSel;
        logic [31:0] expRdata;
        logic        expErr;
        int          expEdges;
    } vec_t;

    vec_t vecs[10];

    // Compares one value and records the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearDownstream();
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
    endtask

    // Plays one transaction, acting as both downstream ports.
    // Must be called between clock edges while the DUT is in IDLE.
    task automatic applyStimulus(input vec_t v);
        bit issued;
        bit done;
        int issueCnt;
        int waitCnt;
        int edges;
        logic selValid;
        logic othValid;
        issued   = 1'b0;
        done     = 1'b0;
        issueCnt = 0;
        waitCnt  = 0;
        edges    = 0;
        m0_rdata = v.expSel ? 32'hBAD0_BAD0 : v.rdata;
        m1_rdata = v.expSel ? v.rdata : 32'hBAD0_BAD0;
        clearDownstream();

        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        checkOutput("readyIdle", req_ready, 1);
        @(posedge clk); #1;
        // Scramble the upstream fields so that only latched values can pass.
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_be    = ~v.be;

        for (int c = 0; c < 40 && !done; c++) begin
            clearDownstream();
            selValid = v.expSel ? m1_valid : m0_valid;
            othValid = v.expSel ? m0_valid : m1_valid;
            checkOutput("otherValidLow", othValid, 0);
            if (rsp_valid) begin
                done = 1'b1;
                checkOutput("rspEdges", 64'(c), 64'(v.expEdges));
                checkOutput("rspRdata", rsp_rdata, v.expRdata);
                checkOutput("rspErr", rsp_err, v.expErr);
                checkOutput("selValidInResp", selValid, 0);
                checkOutput("readyInResp", req_ready, 0);
            end else begin
                checkOutput("readyBusy", req_ready, 0);
                checkOutput("rspValidLow", rsp_valid, 0);
                if (!issued) begin
                    checkOutput("selValidIssue", selValid, 1);
                    checkOutput("mWe",    v.expSel ? m1_we    : m0_we,    v.we);
                    checkOutput("mAddr",  v.expSel ? m1_addr  : m0_addr,  v.addr);
                    checkOutput("mWdata", v.expSel ? m1_wdata : m0_wdata, v.wdata);
                    checkOutput("mBe",    v.expSel ? m1_be    : m0_be,    v.be);
                    if (issueCnt >= v.readyDly) begin
                        if (v.expSel) m1_ready = 1'b1;
                        else          m0_ready = 1'b1;
                        issued = 1'b1;
                    end
                    issueCnt++;
                end else begin
                    checkOutput("selValidWait", selValid, 0);
                    if (v.stray && waitCnt == 0) begin
                        if (v.expSel) m0_rvalid = 1'b1;
                        else          m1_rvalid = 1'b1;
                    end
                    if (waitCnt >= v.rvalidDly) begin
                        if (v.expSel) m1_rvalid = 1'b1;
                        else          m0_rvalid = 1'b1;
                    end
                    waitCnt++;
                end
                @(posedge clk); #1;
                edges = c + 1;
            end
        end
        if (!done) checkOutput("rspWithinBound", 64'(edges), 64'(v.expEdges));

        // Cycle after RESP: back in IDLE, with the response fields held.
        clearDownstream();
        @(posedge clk); #1;
        checkOutput("postRspValid", rsp_valid, 0);
        checkOutput("postRspRdataHeld", rsp_rdata, v.expRdata);
        checkOutput("postRspErrHeld", rsp_err, v.expErr);
        checkOutput("postReady", req_ready, 1);
        checkOutput("postM0Valid", m0_valid, 0);
        checkOutput("postM1Valid", m1_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //         we    addr          wdata         be       rdy  rv  rdata         stray sel   expRdata      err   edges
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF,    0,   0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2};
        vecs[1] = '{1'b1, 32'h0000_8004, 32'h0000_0055, 4'b0001, 3,   0, 32'h1234_5678, 1'b0, 1'b1, 32'h0,         1'b0, 5};
        vecs[2] = '{1'b0, 32'h0000_8000, 32'h0,        4'hF,    255, 0, 32'h7777_7777, 1'b0, 1'b1, 32'h0,         1'b1, 16};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,        4'hF,    1,   2, 32'hCAFE_0001, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 5};
        vecs[4] = '{1'b0, 32'h8000_8010, 32'h0,        4'hF,    0,   0, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0, 2};
        vecs[5] = '{1'b0, 32'h0000_FFFC, 32'h0,        4'hF,    0,   1, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'h0F0F_0F0F, 1'b0, 3};
        vecs[6] = '{1'b0, 32'h0000_7FFC, 32'h0,        4'hF,    0,   0, 32'h1357_9BDF, 1'b0, 1'b0, 32'h1357_9BDF, 1'b0, 2};
        vecs[7] = '{1'b0, 32'h0000_0100, 32'h0,        4'hF,    0,   14, 32'h600D_F00D, 1'b0, 1'b0, 32'h600D_F00D, 1'b0, 16};
        vecs[8] = '{1'b0, 32'h0000_0104, 32'h0,        4'hF,    0,   15, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0,         1'b1, 16};
        vecs[9] = '{1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'hF,    2,   2, 32'h9999_9999, 1'b0, 1'b0, 32'h0,         1'b0, 6};

        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        clearDownstream();

        // Reset state, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetReady", req_ready, 0);
        checkOutput("resetRspValid", rsp_valid, 0);
        checkOutput("resetRspRdata", rsp_rdata, 0);
        checkOutput("resetRspErr", rsp_err, 0);
        checkOutput("resetM0Valid", m0_valid, 0);
        checkOutput("resetM1Valid", m1_valid, 0);
        checkOutput("resetM1Addr", m1_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("readyAfterRelease", req_ready, 1);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Back-to-back: req_valid held high across two requests.
        m0_rdata  = 32'h0000_0011;
        m1_rdata  = 32'h0000_0022;
        m0_ready  = 1'b1;
        m0_rvalid = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0020;
        req_be    = 4'hF;
        @(posedge clk); #1;
        checkOutput("b2bReadyIssue", req_ready, 0);
        checkOutput("b2bM0Valid", m0_valid, 1);
        @(posedge clk); #1;
        checkOutput("b2bReadyWait", req_ready, 0);
        req_addr = 32'h0000_8008;
        @(posedge clk); #1;
        checkOutput("b2bRsp1Valid", rsp_valid, 1);
        checkOutput("b2bRsp1Rdata", rsp_rdata, 32'h0000_0011);
        checkOutput("b2bReadyResp", req_ready, 0);
        @(posedge clk); #1;
        checkOutput("b2bIdleReady", req_ready, 1);
        checkOutput("b2bIdleM1Valid", m1_valid, 0);
        m0_ready  = 1'b0;
        m0_rvalid = 1'b0;
        m1_ready  = 1'b1;
        m1_rvalid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("b2bSecondM1Valid", m1_valid, 1);
        checkOutput("b2bSecondM1Addr", m1_addr, 32'h0000_8008);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("b2bRsp2Valid", rsp_valid, 1);
        checkOutput("b2bRsp2Rdata", rsp_rdata, 32'h0000_0022);
        clearDownstream();
        @(posedge clk); #1;

        // Abandon a transaction by asserting reset while it is in WAIT.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0040;
        m0_rdata  = 32'h4444_4444;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m0_ready  = 1'b1;
        @(posedge clk); #1;
        m0_ready = 1'b0;
        checkOutput("midWaitM0Valid", m0_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstReady", req_ready, 0);
        checkOutput("midRstRspValid", rsp_valid, 0);
        checkOutput("midRstRspRdata", rsp_rdata, 0);
        checkOutput("midRstM0Valid", m0_valid, 0);
        checkOutput("midRstM0Addr", m0_addr, 0);
        m0_rvalid = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRstNoRsp", rsp_valid, 0);
        m0_rvalid = 1'b0;
        rst_n     = 1'b1;
        #1;
        checkOutput("midRstReleaseReady", req_ready, 1);
        @(posedge clk); #1;
        checkOutput("midRstStillNoRsp", rsp_valid, 0);
        applyStimulus(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
